decode_queue: RTL and testbench

- Decode-stage front end for the MIPS pipeline: a DEPTH-entry instruction queue with a registered decode output stage that feeds the execute stage through valid/ready handshakes.
- Successor to the purely combinational main decoder. Adds buffering, backpressure and flush.
- Extends decoding with jump-register, link, CP0, syscall/break/eret and reserved-instruction (RI) detection. Unknown opcodes and REGIMM rt values raise RI instead of silently decoding to zero.

---
 rtl/decode_queue_pkg.sv | 99 +++++++++
 rtl/decode_queue_if.sv | 32 +++
 rtl/decode_queue_instr_decode.sv | 108 ++++++++++
 rtl/decode_queue.sv | 121 ++++++++++++
 tb/tb_decode_queue.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: shared types and encodings for the decode-stage queue.
//   ctrl_t  - 17-bit decoded control word, MSB to LSB:
//             regwrite, regdst, alusrc, branch, memwrite, memtoreg[1:0],
//             gprtohi, gprtolo, jump, jumpr, link, cp0write, syscall, brk,
//             eret, ri
//   OP_*/FN_*/RT_*/RS_* - MIPS opcode, funct, REGIMM rt and COP0 rs fields.
package decode_queue_pkg;

  localparam int CTRL_W = 17;

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic       branch;
    logic       memwrite;
    logic [1:0] memtoreg;
    logic       gprtohi;
    logic       gprtolo;
    logic       jump;
    logic       jumpr;
    logic       link;
    logic       cp0write;
    logic       syscall;
    logic       brk;
    logic       eret;
    logic       ri;
  } ctrl_t;

  // opcodes
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_COP0   = 6'b010000;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_LHU    = 6'b100101;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type funct
  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_SLLV    = 6'b000100;
  localparam logic [5:0] FN_SRLV    = 6'b000110;
  localparam logic [5:0] FN_SRAV    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_BREAK   = 6'b001101;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MTHI    = 6'b010001;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MTLO    = 6'b010011;
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_DIVU    = 6'b011011;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_SLTU    = 6'b101011;
  localparam logic [5:0] FN_ERET    = 6'b011000;

  // REGIMM rt
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // COP0 rs
  localparam logic [4:0] RS_MFC0 = 5'b00000;
  localparam logic [4:0] RS_MTC0 = 5'b00100;
  localparam logic [4:0] RS_CO   = 5'b10000;

endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side push, execute-side pop and flush for the queue.
//   master - fetch/execute side: drives flush, in_valid/in_instr/in_pc,
//            out_ready; observes in_ready, out_*, count.
//   slave  - the queue itself.
interface decode_queue_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 3
);
  import decode_queue_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [PC_W-1:0]  out_pc;
  ctrl_t            out_ctrl;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_ctrl, count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_ctrl, count
  );
endinterface

// File: rtl/decode_queue_instr_decode.sv
// instr_decode: combinational MIPS main decoder, instr_i -> ctrl_o.
//   instr_i - 32-bit instruction word
//   ctrl_o  - control word; unknown encodings set only ri
//   ENABLE_CP0 - 0 makes every COP0 opcode reserved
module instr_decode
  import decode_queue_pkg::*;
#(
  parameter int ENABLE_CP0 = 1
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  logic [5:0] op, funct;
  logic [4:0] rs, rt;

  assign op    = instr_i[31:26];
  assign rs    = instr_i[25:21];
  assign rt    = instr_i[20:16];
  assign funct = instr_i[5:0];

  // ri is only ever set from branches that set nothing else
  always_comb begin
    ctrl_o = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.regdst   = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            ctrl_o.gprtohi = 1'b1;
            ctrl_o.gprtolo = 1'b1;
          end
          FN_MFHI: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.regdst   = 1'b1;
            ctrl_o.memtoreg = 2'b10;
          end
          FN_MFLO: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.regdst   = 1'b1;
            ctrl_o.memtoreg = 2'b11;
          end
          FN_MTHI:    ctrl_o.gprtohi = 1'b1;
          FN_MTLO:    ctrl_o.gprtolo = 1'b1;
          FN_JR:      ctrl_o.jumpr   = 1'b1;
          FN_JALR: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.regdst   = 1'b1;
            ctrl_o.jumpr    = 1'b1;
            ctrl_o.link     = 1'b1;
          end
          FN_SYSCALL: ctrl_o.syscall = 1'b1;
          FN_BREAK:   ctrl_o.brk     = 1'b1;
          default:    ctrl_o.ri      = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: ctrl_o.branch = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin
            ctrl_o.branch   = 1'b1;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.link     = 1'b1;
          end
          default: ctrl_o.ri = 1'b1;
        endcase
      end
      OP_J: ctrl_o.jump = 1'b1;
      OP_JAL: begin
        ctrl_o.jump     = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.link     = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ctrl_o.branch = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
      end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memtoreg = 2'b01;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      OP_COP0: begin
        if (ENABLE_CP0 != 0) begin
          if (rs == RS_MFC0)                          ctrl_o.regwrite = 1'b1;
          else if (rs == RS_MTC0)                     ctrl_o.cp0write = 1'b1;
          else if (rs == RS_CO && funct == FN_ERET)   ctrl_o.eret     = 1'b1;
          else                                        ctrl_o.ri       = 1'b1;
        end else begin
          ctrl_o.ri = 1'b1;
        end
      end
      default: ctrl_o.ri = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction queue with a registered decode
// output stage between fetch and execute.
//   clk, rst - rising-edge clock, synchronous active-high reset
//   bus      - decode_queue_if.slave: flush, in_* push handshake,
//              out_* registered decoded output handshake, count occupancy
// The head entry is decoded combinationally and captured into the output
// registers on pop, so there is no path from in_* to out_*.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int PC_W       = 32,
  parameter int ENABLE_CP0 = 1
) (
  input  logic           clk,
  input  logic           rst,
  decode_queue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][31:0]     instr_mem_q;
  logic [DEPTH-1:0][PC_W-1:0] pc_mem_q;

  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  ctrl_t           out_ctrl_q, out_ctrl_d;
  ctrl_t           head_ctrl;
  logic            push, pop;

  instr_decode #(.ENABLE_CP0(ENABLE_CP0)) u_dec (
    .instr_i (instr_mem_q[rptr_q]),
    .ctrl_o  (head_ctrl)
  );

  always_comb begin
    push = bus.in_valid && in_ready_q && !bus.flush;
    pop  = (count_q != '0) && (!out_valid_q || bus.out_ready) && !bus.flush;

    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_ctrl_d  = out_ctrl_q;

    // DEPTH is a power of two, so pointers wrap naturally
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      out_valid_d = 1'b1;
      out_instr_d = instr_mem_q[rptr_q];
      out_pc_d    = pc_mem_q[rptr_q];
      out_ctrl_d  = head_ctrl;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (bus.flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end

    // registered ready: a pop while full only reopens the input next cycle
    in_ready_d = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_ctrl_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_ctrl_q  <= out_ctrl_d;
    end
  end

  // storage needs no reset: entries are only read once count covers them
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wptr_q] <= bus.in_instr;
      pc_mem_q[wptr_q]    <= bus.in_pc;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_ctrl  = out_ctrl_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
  import decode_queue_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [16:0] ctrl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  decode_queue_if #(.PC_W(32), .CNT_W(3)) bus ();
  decode_queue_if #(.PC_W(32), .CNT_W(3)) bus2 ();

  decode_queue #(.DEPTH(4), .PC_W(32), .ENABLE_CP0(1)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );

  decode_queue #(.DEPTH(4), .PC_W(32), .ENABLE_CP0(0)) dut_nocp0 (
    .clk (clk), .rst (rst), .bus (bus2.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called at #1 after a posedge; returns #1 after the accepting posedge
  task automatic push(input logic [31:0] ins, input logic [31:0] pc, input logic [16:0] ctrl);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc    = pc;
    @(negedge clk);
    while (!bus.in_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        nchk++; nerr++;
        $display("FAIL push_timeout: in_ready stayed %b for instr %h", bus.in_ready, ins);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    sb.push_back('{instr: ins, pc: pc, ctrl: ctrl});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    nchk++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d entries outstanding, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic cp0off(input string name, input logic [31:0] ins, input logic [16:0] exp);
    int n = 0;
    @(posedge clk); #1;
    bus2.in_valid  = 1'b1;
    bus2.in_instr  = ins;
    bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    while (!bus2.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_valid"}, 64'(bus2.out_valid), 64'(1));
    chk(name, 64'(bus2.out_ctrl), 64'(exp));
  endtask

  // scoreboard monitor: a handshake completes at the next posedge
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_out: instr %h emerged, none expected", bus.out_instr);
      end else begin
        e = sb.pop_front();
        chk("out_instr", 64'(bus.out_instr), 64'(e.instr));
        chk("out_pc",    64'(bus.out_pc),    64'(e.pc));
        chk("out_ctrl",  64'(bus.out_ctrl),  64'(e.ctrl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] misc_ins [12] = '{32'h7C000000, 32'h04050000, 32'h04100000, 32'h42000018,
                                 32'h40806000, 32'h40026000, 32'h40200000, 32'h03E00008,
                                 32'h0000F809, 32'h00000001, 32'h0000000C, 32'h0000000D};
  logic [16:0] misc_exp [12] = '{17'h00001, 17'h00001, 17'h12020, 17'h00002,
                                 17'h00010, 17'h10000, 17'h00001, 17'h00040,
                                 17'h18060, 17'h00001, 17'h00008, 17'h00004};
  logic [31:0] bp_ins [5] = '{32'h34000000, 32'h10000000, 32'h00850018, 32'h00001010, 32'h00001012};
  logic [16:0] bp_exp [5] = '{17'h14000, 17'h02000, 17'h00300, 17'h18800, 17'h18C00};

  initial begin
    bus.flush = 0; bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 0;
    bus2.flush = 0; bus2.in_valid = 0; bus2.in_instr = '0; bus2.in_pc = '0; bus2.out_ready = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_count",     64'(bus.count),     64'(0));
    chk("rst_out_ctrl",  64'(bus.out_ctrl),  64'(0));
    chk("rst_out_instr", 64'(bus.out_instr), 64'(0));
    chk("rst_out_pc",    64'(bus.out_pc),    64'(0));
    rst = 0;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // first instruction latency
    bus.out_ready = 1;
    push(32'h00851021, 32'hBFC00000, 17'h18000);
    chk("lat_not_yet", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    chk("lat_valid", 64'(bus.out_valid), 64'(1));
    chk("lat_pc",    64'(bus.out_pc),    64'(32'hBFC00000));
    drain();

    // back-to-back burst at full throughput
    push(32'h8C820004, 32'h00000100, 17'h14400);
    push(32'hAC820004, 32'h00000104, 17'h05000);
    push(32'h0C000010, 32'h00000108, 17'h100A0);
    push(32'h00800011, 32'h0000010C, 17'h00200);
    chk("burst_count", 64'(bus.count), 64'(1));
    @(posedge clk); #1;
    chk("burst_count_empty", 64'(bus.count), 64'(0));
    chk("burst_last_instr",  64'(bus.out_instr), 64'(32'h00800011));
    drain();

    // backpressure: 4 queued + 1 in the output stage
    bus.out_ready = 0;
    for (int i = 0; i < 5; i++) push(bp_ins[i], 32'h200 + 32'(4 * i), bp_exp[i]);
    chk("full_count",    64'(bus.count),    64'(4));
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("hold_instr", 64'(bus.out_instr), 64'(32'h34000000));
    chk("hold_ctrl",  64'(bus.out_ctrl),  64'(17'h14000));
    chk("hold_pc",    64'(bus.out_pc),    64'(32'h200));
    bus.out_ready = 1;
    @(posedge clk); #1;
    chk("release_in_ready", 64'(bus.in_ready), 64'(1));
    drain();

    // reserved, REGIMM, CP0 and jump-register decodes
    for (int i = 0; i < 12; i++) push(misc_ins[i], 32'h300 + 32'(4 * i), misc_exp[i]);
    drain();

    // CP0 disabled instance
    cp0off("nocp0_mtc0", 32'h40806000, 17'h00001);
    cp0off("nocp0_eret", 32'h42000018, 17'h00001);
    cp0off("nocp0_addu", 32'h00851021, 17'h18000);

    // flush with 3 queued and a valid output, alongside a push
    bus.out_ready = 0;
    for (int i = 0; i < 4; i++) push(bp_ins[i], 32'h400 + 32'(4 * i), bp_exp[i]);
    chk("preflush_count", 64'(bus.count), 64'(3));
    bus.flush = 1; bus.in_valid = 1; bus.in_instr = 32'h00851021; bus.in_pc = 32'h500;
    @(posedge clk); #1;
    bus.flush = 0; bus.in_valid = 0;
    sb.delete();
    chk("flush_count",     64'(bus.count),     64'(0));
    chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
    chk("flush_out_ctrl",  64'(bus.out_ctrl),  64'(0));
    bus.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_no_enqueue", 64'(bus.out_valid), 64'(0));
    chk("flush_count_idle", 64'(bus.count),     64'(0));
    push(32'h00800013, 32'h600, 17'h00100);
    drain();

    // synchronous reset with a full queue
    bus.out_ready = 0;
    for (int i = 0; i < 5; i++) push(bp_ins[i], 32'h700 + 32'(4 * i), bp_exp[i]);
    rst = 1;
    @(posedge clk); #1;
    sb.delete();
    chk("mrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mrst_count",     64'(bus.count),     64'(0));
    chk("mrst_out_instr", 64'(bus.out_instr), 64'(0));
    chk("mrst_out_pc",    64'(bus.out_pc),    64'(0));
    chk("mrst_out_ctrl",  64'(bus.out_ctrl),  64'(0));
    chk("mrst_in_ready",  64'(bus.in_ready),  64'(1));
    rst = 0;
    bus.out_ready = 1;
    @(posedge clk); #1;
    push(32'h00851021, 32'h800, 17'h18000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
